cdc_handshake_tx: RTL and testbench
===================================

CDC_HANDSHAKE_TX -- requirements
Module: cdc_handshake_tx

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 8, which is the width of the transferred data word.
REQ-002 The block SHALL have parameter NUM_STAGES, default 2, which is the number of synchronizer flops on the ack input; legal values are 2 or more.
REQ-003 clk  input  1  single source-domain clock; all logic SHALL be rising-edge triggered.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  BUS_WIDTH  word offered by the local producer.
REQ-006 in_valid  input  1  producer has a word on in_data.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 tx_data  output  BUS_WIDTH  registered word presented to the destination domain.
REQ-009 req  output  1  registered request level sent to the destination domain.
REQ-010 ack  input  1  acknowledge level from the destination domain; asynchronous to clk.
REQ-011 done  output  1  one-cycle pulse marking a completed 4-phase transfer.

Function
REQ-012 ack SHALL pass through a NUM_STAGES-deep flop chain clocked by clk before any use; only the last stage (ack_s) SHALL drive control logic.
REQ-013 FSM states SHALL be IDLE, WAIT_ACK_HI and WAIT_ACK_LO.
REQ-014 in_ready SHALL be 1 exactly when the state is IDLE, decoded from the state register, so it is glitch-free.
REQ-015 In IDLE with in_valid=1, at the clock edge the block SHALL latch in_data into tx_data, set req=1 and go to WAIT_ACK_HI.
REQ-016 In IDLE with in_valid=0, all registers SHALL hold their values.
REQ-017 In WAIT_ACK_HI with ack_s=1, the block SHALL set req=0 at the edge and go to WAIT_ACK_LO; otherwise it SHALL hold state and req.
REQ-018 In WAIT_ACK_LO with ack_s=0, the block SHALL go to IDLE at the edge and set done=1 for exactly one cycle; otherwise it SHALL hold state.
REQ-019 tx_data SHALL change only on acceptance (REQ-015), and SHALL be stable from the rise of req until the return to IDLE.
REQ-020 req SHALL be driven directly from a flop, with no combinational path to it.
REQ-021 in_data and in_valid SHALL be ignored outside IDLE; there is no buffering and no overwrite.
REQ-022 An ack_s=1 seen in IDLE (spurious or stale) SHALL be ignored, with no state change and no done.
REQ-023 If ack_s is already 1 on entering WAIT_ACK_HI, req SHALL fall on the next edge, giving a minimum req-high time of 1 cycle.
REQ-024 Latency: from the acceptance edge, req rises after 1 edge; req falls NUM_STAGES+1 edges after ack rises (with ack meeting setup); IDLE is re-entered NUM_STAGES+1 edges after ack falls.
REQ-025 Back-to-back operation: a word offered in the same cycle done=1 SHALL be accepted on the next edge, since in_ready=1 in that cycle.
REQ-026 The block SHALL impose no timeout; it waits indefinitely for ack.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL set state=IDLE, req=0, tx_data=0, done=0 and clear every synchronizer flop to 0.
REQ-028 A reset asserted mid-transfer SHALL abort it: req=0 after that edge, no done pulse, and in_ready=1 in the cycle after rst is released.
REQ-029 rst SHALL take priority over all other inputs.

Verification
REQ-030 A bench SHALL cover these directed scenarios, with NUM_STAGES=2 and BUS_WIDTH=8:
- Single transfer: in_data=0xA5, in_valid=1 for 1 cycle; ack echoes req after a 3-cycle delay -> tx_data=0xA5 held, req high until 3 edges after ack rises, one done pulse, in_ready returns to 1.
- Back-to-back: words 0x01 and 0x02 with in_valid held high -> two complete handshakes, tx_data sequence 0x01 then 0x02, exactly 2 done pulses, no word lost.
- Spurious ack: ack pulsed high for 4 cycles while IDLE -> req stays 0, no done, state stays IDLE.
- Slow ack: ack held low for 100 cycles after req rises -> req stays 1, tx_data stable, in_ready=0 throughout.
- Reset mid-transfer: rst=1 for 1 cycle during WAIT_ACK_HI with in_data=0x3C latched -> req=0, tx_data=0x00, no done, new word accepted afterwards.
- Ignored input: in_data toggled while in WAIT_ACK_LO -> tx_data unchanged.

Source files
------------

// File: rtl/cdc_handshake_tx_if.sv
// Bundle of signals between the local producer, the 4-phase request sender
// and the destination-domain acknowledger.
interface cdc_handshake_tx_if #(
    parameter int BUS_WIDTH = 8
);
    logic [BUS_WIDTH-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [BUS_WIDTH-1:0] tx_data;
    logic                 req;
    logic                 ack;
    logic                 done;

    // Driven side: producer plus the far-domain acknowledger.
    modport master (
        output in_data, in_valid, ack,
        input  in_ready, tx_data, req, done
    );

    // The request sender itself.
    modport slave (
        input  in_data, in_valid, ack,
        output in_ready, tx_data, req, done
    );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack handshake. Holds one word stable on tx_data
// while req/ack complete a full cycle; ack is resynchronized before use.
module cdc_handshake_tx #(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2
) (
    input logic              clk,
    input logic              rst,
    cdc_handshake_tx_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_ACK_HI = 2'd1,
        WAIT_ACK_LO = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic                  req_q, req_d;
    logic                  done_q, done_d;
    logic [BUS_WIDTH-1:0]  tx_data_q, tx_data_d;
    logic                  ack_s;

    // Only the last synchronizer stage may reach control logic.
    assign ack_sync_d = {ack_sync_q[NUM_STAGES-2:0], bus.ack};
    assign ack_s      = ack_sync_q[NUM_STAGES-1];

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        tx_data_d = tx_data_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A stale ack_s here is deliberately not looked at.
                if (bus.in_valid) begin
                    tx_data_d = bus.in_data;
                    req_d     = 1'b1;
                    state_d   = WAIT_ACK_HI;
                end
            end
            WAIT_ACK_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = WAIT_ACK_LO;
                end
            end
            WAIT_ACK_LO: begin
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ack_sync_q <= '0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ack_sync_q <= ack_sync_d;
            req_q      <= req_d;
            done_q     <= done_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.req      = req_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.done     = done_q;

    // The completion pulse always coincides with being ready again.
    a_done_in_idle: assert property (@(posedge clk) disable iff (rst)
        done_q |-> (state_q == IDLE));
    a_done_single: assert property (@(posedge clk) disable iff (rst)
        done_q |=> !done_q);
endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: vector table, directed multi-cycle sequences,
// then randomized traffic against a transaction-level reference model.
module tb_cdc_handshake_tx;
    localparam int BW = 8;
    localparam int NS = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cdc_handshake_tx_if #(.BUS_WIDTH(BW)) bus ();
    cdc_handshake_tx #(.BUS_WIDTH(BW), .NUM_STAGES(NS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic v, input logic [BW-1:0] d, input logic a);
        rst          = r;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.ack      = a;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          rst;
        logic          vld;
        logic [BW-1:0] din;
        logic          ack;
        logic          exp_req;
        logic          exp_rdy;
        logic          exp_done;
        logic [BW-1:0] exp_tx;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic v, input logic [BW-1:0] d, input logic a,
                                input logic er, input logic erdy, input logic ed, input logic [BW-1:0] et);
        vec_t x;
        x.rst = r; x.vld = v; x.din = d; x.ack = a;
        x.exp_req = er; x.exp_rdy = erdy; x.exp_done = ed; x.exp_tx = et;
        tbl.push_back(x);
    endfunction

    // ---------------- reference model ----------------
    // Transfer phase: 0 = free, 1 = request out, 2 = waiting for ack to drop.
    int            phase;
    logic          m_req, m_done;
    logic [BW-1:0] m_tx;
    logic          ack_hist[$];

    task automatic model_edge(input logic r, input logic v, input logic [BW-1:0] d, input logic a);
        logic seen;
        // The block reacts to the ack level that was sampled NS edges ago.
        seen   = (ack_hist.size() >= NS) ? ack_hist[ack_hist.size()-NS] : 1'b0;
        m_done = 1'b0;
        if (r) begin
            phase = 0;
            m_req = 1'b0;
            m_tx  = '0;
            ack_hist.delete();
        end else begin
            if (phase == 0 && v) begin
                m_tx  = d;
                m_req = 1'b1;
                phase = 1;
            end else if (phase == 1 && seen) begin
                m_req = 1'b0;
                phase = 2;
            end else if (phase == 2 && !seen) begin
                m_done = 1'b1;
                phase  = 0;
            end
            ack_hist.push_back(a);
            if (ack_hist.size() > 8) void'(ack_hist.pop_front());
        end
    endtask

    initial begin
        int            n, bad, n_done, n_acc, t_done1, t_acc2;
        logic [BW-1:0] seq[2];
        logic          prev_req, r, v, a;
        logic [BW-1:0] d;

        // rst vld din ack | req rdy done tx
        add(1, 0, 8'h00, 0,  0, 1, 0, 8'h00);
        // single transfer, ack echoes req 3 cycles later
        add(0, 1, 8'hA5, 0,  1, 0, 0, 8'hA5);
        add(0, 0, 8'h00, 0,  1, 0, 0, 8'hA5);
        add(0, 0, 8'h00, 0,  1, 0, 0, 8'hA5);
        add(0, 0, 8'h00, 1,  1, 0, 0, 8'hA5);
        add(0, 0, 8'h00, 1,  1, 0, 0, 8'hA5);
        add(0, 0, 8'h00, 1,  0, 0, 0, 8'hA5);
        add(0, 0, 8'h00, 0,  0, 0, 0, 8'hA5);
        add(0, 0, 8'h00, 0,  0, 0, 0, 8'hA5);
        add(0, 0, 8'h00, 0,  0, 1, 1, 8'hA5);
        add(0, 0, 8'h00, 0,  0, 1, 0, 8'hA5);
        // spurious ack while idle
        for (int i = 0; i < 4; i++) add(0, 0, 8'h00, 1,  0, 1, 0, 8'hA5);
        for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 0,  0, 1, 0, 8'hA5);
        // reset while a request is outstanding, rst beats in_valid
        add(0, 1, 8'h3C, 0,  1, 0, 0, 8'h3C);
        add(0, 0, 8'h00, 0,  1, 0, 0, 8'h3C);
        add(1, 1, 8'h77, 0,  0, 1, 0, 8'h00);
        add(0, 1, 8'h5A, 1,  1, 0, 0, 8'h5A);
        add(0, 0, 8'h00, 1,  1, 0, 0, 8'h5A);
        add(0, 0, 8'h00, 1,  0, 0, 0, 8'h5A);
        add(0, 0, 8'h00, 0,  0, 0, 0, 8'h5A);
        add(0, 0, 8'h00, 0,  0, 0, 0, 8'h5A);
        add(0, 0, 8'h00, 0,  0, 1, 1, 8'h5A);
        add(0, 0, 8'h00, 0,  0, 1, 0, 8'h5A);
        // ack already high on entry: one-cycle request
        add(0, 0, 8'h00, 1,  0, 1, 0, 8'h5A);
        add(0, 0, 8'h00, 1,  0, 1, 0, 8'h5A);
        add(0, 1, 8'hC3, 1,  1, 0, 0, 8'hC3);
        add(0, 0, 8'h00, 1,  0, 0, 0, 8'hC3);
        add(0, 0, 8'h00, 0,  0, 0, 0, 8'hC3);
        add(0, 0, 8'h00, 0,  0, 0, 0, 8'hC3);
        add(0, 0, 8'h00, 0,  0, 1, 1, 8'hC3);
        add(0, 0, 8'h00, 0,  0, 1, 0, 8'hC3);

        drive(1, 0, '0, 0);
        tick();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].din, tbl[i].ack);
            tick();
            check($sformatf("vec%0d_req", i),  bus.req,      tbl[i].exp_req);
            check($sformatf("vec%0d_rdy", i),  bus.in_ready, tbl[i].exp_rdy);
            check($sformatf("vec%0d_done", i), bus.done,     tbl[i].exp_done);
            check($sformatf("vec%0d_tx", i),   bus.tx_data,  tbl[i].exp_tx);
        end

        // ---- slow ack, then ignored input while waiting for ack to fall ----
        drive(0, 1, 8'h96, 0);
        tick();
        check("slow_accept_req", bus.req, 1'b1);
        check("slow_accept_tx", bus.tx_data, 8'h96);
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            drive(0, c[0], c[7:0], 0);
            tick();
            if (bus.req !== 1'b1 || bus.tx_data !== 8'h96 || bus.in_ready !== 1'b0) bad++;
        end
        check("slow_ack_hold_errors", bad, 0);
        drive(0, 0, '0, 1);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n++;
            if (bus.req === 1'b0) break;
        end
        check("req_fall_latency", n, NS + 1);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            drive(0, 1, 8'hF0 ^ c[7:0], 1);
            tick();
            if (bus.tx_data !== 8'h96 || bus.req !== 1'b0 || bus.in_ready !== 1'b0) bad++;
        end
        check("ignored_input_errors", bad, 0);
        drive(0, 0, '0, 0);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n++;
            if (bus.done === 1'b1) break;
        end
        check("done_latency", n, NS + 1);
        check("done_tx_kept", bus.tx_data, 8'h96);
        tick();
        check("done_one_cycle", bus.done, 1'b0);

        // ---- back-to-back with in_valid held high ----
        n_done = 0; n_acc = 0; t_done1 = -1; t_acc2 = -1; prev_req = 1'b0;
        seq[0] = '0; seq[1] = '0;
        drive(0, 1, 8'h01, 0);
        for (int c = 0; c < 80; c++) begin
            tick();
            if (bus.req && !prev_req) begin
                if (n_acc < 2) seq[n_acc] = bus.tx_data;
                n_acc++;
                if (n_acc == 1) bus.in_data = 8'h02;
                else begin
                    bus.in_valid = 1'b0;
                    t_acc2 = c;
                end
            end
            if (bus.done) begin
                n_done++;
                if (n_done == 1) t_done1 = c;
            end
            prev_req = bus.req;
            bus.ack  = bus.req;
        end
        check("b2b_accepts", n_acc, 2);
        check("b2b_dones", n_done, 2);
        check("b2b_word0", seq[0], 8'h01);
        check("b2b_word1", seq[1], 8'h02);
        check("b2b_gap", t_acc2, t_done1 + 1);

        // ---- randomized traffic against the model ----
        drive(1, 0, '0, 0);
        model_edge(1, 0, '0, 0);
        tick();
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom % 256) == 0;
            v = ($urandom % 3) != 0;
            d = BW'($urandom);
            a = bus.ack;
            if (bus.ack != bus.req && ($urandom % 3) == 0) a = bus.req;
            else if (!bus.req && !bus.ack && ($urandom % 40) == 0) a = 1'b1;
            drive(r, v, d, a);
            model_edge(r, v, d, a);
            tick();
            check("rand_req",  bus.req,      m_req);
            check("rand_rdy",  bus.in_ready, phase == 0);
            check("rand_done", bus.done,     m_done);
            check("rand_tx",   bus.tx_data,  m_tx);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
